// File: rtl/apb_regbank_pkg.sv
// Shared types and constants for the APB register-bank completer.
// Holds the FSM state encoding, the byte-strobe width helper and the fixed register/bit indices.
package apb_regbank_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;
  localparam int          REG0_IDX         = 0;
  localparam int          PRIV_BIT         = 0;
  localparam int          CNT_WIDTH        = 4;

  function automatic int strb_width(input int w);
    return (w + 7) / 8;
  endfunction
endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter that paces the wait states of an access phase.
// It stops at zero and exposes a zero flag.
module apb_wait_counter
  import apb_regbank_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      count <= '0;
    else if (load)                  count <= load_val;
    else if (dec && count != '0)    count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/apb_regbank_slave.sv
// APB completer that maps one select line onto a bank of word registers.
// It supports wait states, byte strobes, a read-only ID register and a privileged upper half.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 3,
  parameter int          SEL_WIDTH   = 2,
  parameter int          SEL_INDEX   = 0,
  parameter int          WRITE_WIDTH = 32,
  parameter int          READ_WIDTH  = WRITE_WIDTH,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT,
  localparam int         STRB_WIDTH  = strb_width(WRITE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [2:0]             prot,
  input  logic [SEL_WIDTH-1:0]   sel,
  input  logic                   enable,
  input  logic                   write,
  input  logic [WRITE_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0]  strb,
  output logic                   ready,
  output logic [READ_WIDTH-1:0]  rdata,
  output logic                   slv_err
);
  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] REG0 = ADDR_WIDTH'(REG0_IDX);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  l_addr;
  logic                   l_write, l_priv;
  logic [WRITE_WIDTH-1:0] l_wdata;
  logic [STRB_WIDTH-1:0]  l_strb;
  logic [WRITE_WIDTH-1:0] regs [NREGS];

  logic                   me, setup, cnt_zero, err;
  logic [WRITE_WIDTH-1:0] mask, cur;
  logic                   unused_bits;

  assign me          = sel[SEL_INDEX];
  assign setup       = (state == IDLE) && me && !enable;
  assign unused_bits = ^{prot, sel};

  apb_wait_counter #(.WIDTH(CNT_WIDTH)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (setup),
    .dec      (state == ACCESS),
    .load_val (CNT_WIDTH'(WAIT_STATES)),
    .zero     (cnt_zero)
  );

  // Everything below decodes latched state only, so no bus input reaches an output.
  assign ready   = (state == ACCESS) && cnt_zero;
  assign err     = (l_write && l_addr == REG0) || (l_addr[ADDR_WIDTH-1] && !l_priv);
  assign cur     = (l_addr == REG0) ? WRITE_WIDTH'(ID_VALUE) : regs[l_addr];
  assign rdata   = (ready && !l_write && !err) ? READ_WIDTH'(cur) : '0;
  assign slv_err = ready && err;

  // Bit-level mask so a partial top byte lane only covers the bits that exist.
  always_comb begin
    mask = '0;
    for (int b = 0; b < WRITE_WIDTH; b++) mask[b] = l_strb[b / 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      l_addr  <= '0;
      l_write <= 1'b0;
      l_priv  <= 1'b0;
      l_wdata <= '0;
      l_strb  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (setup) begin
          state   <= ACCESS;
          l_addr  <= addr;
          l_write <= write;
          l_wdata <= wdata;
          l_strb  <= strb;
          l_priv  <= prot[PRIV_BIT];
        end
        ACCESS: begin
          if (!(me && enable)) begin
            state <= IDLE;
          end else if (ready) begin
            state <= IDLE;
            if (l_write && !err) regs[l_addr] <= (regs[l_addr] & ~mask) | (l_wdata & mask);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave: one instance with one wait state on sel[0],
// one with zero wait states on sel[1], sharing the same bus.
module tb_apb_regbank_slave;
  logic        clk, reset;
  logic [2:0]  addr, prot;
  logic [1:0]  sel;
  logic        enable, write;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic        ready0, ready1, err0, err1;
  logic [31:0] rdata0, rdata1;

  int errors = 0;
  int checks = 0;

  apb_regbank_slave #(.SEL_INDEX(0), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .addr(addr), .prot(prot), .sel(sel), .enable(enable),
    .write(write), .wdata(wdata), .strb(strb), .ready(ready0), .rdata(rdata0), .slv_err(err0));

  apb_regbank_slave #(.SEL_INDEX(1), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .addr(addr), .prot(prot), .sel(sel), .enable(enable),
    .write(write), .wdata(wdata), .strb(strb), .ready(ready1), .rdata(rdata1), .slv_err(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the completion edge.
  task automatic xfer(input int d, input logic [2:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int acyc);
    bit got;
    got = 0; acyc = 0; rd = 32'hFFFF_FFFF; er = 1'bx;
    addr = a; write = w; wdata = wd; strb = st; prot = pr; enable = 1'b0;
    sel = (d == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    enable = 1'b1; addr = ~a; wdata = ~wd;
    for (int i = 1; i <= 16 && !got; i++) begin
      @(negedge clk);
      if ((d == 0) ? ready0 : ready1) begin
        got = 1; acyc = i;
        rd = (d == 0) ? rdata0 : rdata1;
        er = (d == 0) ? err0 : err1;
      end
      @(posedge clk); #1;
    end
    sel = 2'b00; enable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          ac;
    time         tprev;

    reset = 1'b1; addr = '0; prot = '0; sel = '0; enable = 1'b0; write = 1'b0;
    wdata = '0; strb = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_err0",   {31'd0, err0}, 32'd0);
    chk("rst_ready1", {31'd0, ready1}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    xfer(0, 3'd0, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, ac);
    chk("id_lat", ac, 32'd2);
    chk("id_rdata", rd, 32'hA5B0_0001);
    chk("id_err", {31'd0, er}, 32'd0);

    xfer(0, 3'd2, 1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b000, rd, er, ac);
    chk("w2_full_err", {31'd0, er}, 32'd0);
    xfer(0, 3'd2, 1'b1, 32'h0000_1200, 4'b0010, 3'b000, rd, er, ac);
    chk("w2_lane1_err", {31'd0, er}, 32'd0);
    xfer(0, 3'd2, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, ac);
    chk("r2_strb", rd, 32'hDEAD_12EF);

    xfer(0, 3'd5, 1'b1, 32'h1, 4'hF, 3'b000, rd, er, ac);
    chk("w5_unpriv_err", {31'd0, er}, 32'd1);
    chk("w5_unpriv_lat", ac, 32'd2);
    xfer(0, 3'd5, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, ac);
    chk("r5_priv_data", rd, 32'd0);
    chk("r5_priv_err", {31'd0, er}, 32'd0);
    xfer(0, 3'd5, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, ac);
    chk("r5_unpriv_err", {31'd0, er}, 32'd1);
    chk("r5_unpriv_data", rd, 32'd0);
    xfer(0, 3'd5, 1'b1, 32'h0000_1234, 4'hF, 3'b001, rd, er, ac);
    chk("w5_priv_err", {31'd0, er}, 32'd0);
    xfer(0, 3'd5, 1'b0, 32'h0, 4'h0, 3'b111, rd, er, ac);
    chk("r5_priv_new", rd, 32'h0000_1234);

    xfer(0, 3'd0, 1'b1, 32'h1234_5678, 4'hF, 3'b001, rd, er, ac);
    chk("w0_err", {31'd0, er}, 32'd1);
    xfer(0, 3'd0, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, ac);
    chk("r0_id_kept", rd, 32'hA5B0_0001);

    // Abort: enable falls during the single wait cycle of a write to reg 3.
    addr = 3'd3; write = 1'b1; wdata = 32'h55; strb = 4'hF; prot = 3'b001;
    sel = 2'b01; enable = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    chk("abort_wait_ready", {31'd0, ready0}, 32'd0);
    #1 enable = 1'b0;
    @(posedge clk); #1 sel = 2'b00;
    @(negedge clk);
    chk("abort_no_ready_a", {31'd0, ready0}, 32'd0);
    @(negedge clk);
    chk("abort_no_ready_b", {31'd0, ready0}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 3'd3, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, ac);
    chk("abort_r3", rd, 32'd0);

    // Other instance must not have seen any of the sel[0] traffic.
    xfer(1, 3'd2, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, ac);
    chk("iso_r2_dut1", rd, 32'd0);
    chk("iso_lat_dut1", ac, 32'd1);

    // Reset while the write to reg 1 is presenting ready.
    addr = 3'd1; write = 1'b1; wdata = 32'hFFFF_FFFF; strb = 4'hF; prot = 3'b001;
    sel = 2'b01; enable = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_pre", {31'd0, ready0}, 32'd1);
    #1 reset = 1'b1;
    #1 chk("rst_mid_ready", {31'd0, ready0}, 32'd0);
    @(posedge clk); #1 reset = 1'b0; sel = 2'b00; enable = 1'b0;
    xfer(0, 3'd1, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, ac);
    chk("rst_mid_r1", rd, 32'd0);

    // Back-to-back writes then reads on the zero-wait instance.
    tprev = 0;
    for (int i = 1; i <= 7; i++) begin
      xfer(1, 3'(i), 1'b1, 32'h1111_1111 * i, 4'hF, 3'b001, rd, er, ac);
      chk("b2b_w_err", {31'd0, er}, 32'd0);
      chk("b2b_w_lat", ac, 32'd1);
      if (i > 1) chk("b2b_w_gap", 32'($time - tprev), 32'd20);
      tprev = $time;
    end
    for (int i = 1; i <= 7; i++) begin
      xfer(1, 3'(i), 1'b0, 32'h0, 4'h0, 3'b001, rd, er, ac);
      chk("b2b_r_data", rd, 32'h1111_1111 * i);
      chk("b2b_r_gap", 32'($time - tprev), 32'd20);
      tprev = $time;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_regbank_slave.md
# apb_regbank_slave

APB completer that terminates one select line of the bench's APB bus in a bank of `2**ADDR_WIDTH` word registers, with programmable wait states, byte strobes, privilege checking and error response. It is the responder-side DUT driven by the bench's master agent. The master agent drives `addr`, `prot`, `sel`, `enable`, `write`, `wdata` and `strb`. This block returns `ready`, `rdata` and `slv_err`.

## Interface
- `ADDR_WIDTH`, 3: register index width; the bank holds `2**ADDR_WIDTH` registers, and `addr` is a word index, not a byte address.
- `SEL_WIDTH`, 2: width of the bus select vector.
- `SEL_INDEX`, 0: bit of `sel` that selects this completer.
- `WRITE_WIDTH`, 32: register and `wdata` width.
- `READ_WIDTH`, `WRITE_WIDTH`: `rdata` width; register value zero-extended or truncated to fit.
- `WAIT_STATES`, 1: number of access cycles with `ready` low before completion (0..15).
- `ID_VALUE`, 32'hA5B0_0001: read-only content of register 0.
- `clk`  in  1: sole clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `addr`  in  `ADDR_WIDTH`: register index.
- `prot`  in  3: protection; only `prot[0]` (privileged) is used.
- `sel`  in  `SEL_WIDTH`: select vector; only `sel[SEL_INDEX]` is used.
- `enable`  in  1: access-phase marker.
- `write`  in  1: 1 = write, 0 = read.
- `wdata`  in  `WRITE_WIDTH`: write data.
- `strb`  in  `STRB_WIDTH`: byte-lane write enables, `STRB_WIDTH` = ceil(`WRITE_WIDTH`/8).
- `ready`  out  1: transfer completion.
- `rdata`  out  `READ_WIDTH`: read data, valid only when `ready`=1.
- `slv_err`  out  1: error response, valid only when `ready`=1.

## Operation
- Reset: FSM goes to `IDLE`, wait counter to 0, registers 1..N-1 to 0. Outputs `ready`=0, `rdata`=0, `slv_err`=0.
- FSM has two states, `IDLE` and `ACCESS`.
- `IDLE` to `ACCESS` when `sel[SEL_INDEX]`=1 and `enable`=0 (setup phase).
  - At that edge the block latches `addr`, `write`, `wdata`, `strb` and `prot[0]`.
  - The wait counter loads `WAIT_STATES`.
- In `ACCESS`:
  - While the counter is not 0, it decrements each cycle and `ready` stays 0.
  - When the counter is 0, `ready`=1. The transfer completes at the edge where `sel[SEL_INDEX]` & `enable` & `ready`, and the FSM returns to `IDLE`.
  - If `sel[SEL_INDEX]` or `enable` falls before completion, the transfer is aborted: return to `IDLE`, no register update, no response.
- Error conditions, evaluated on the latched values:
  - Write to register 0 (read-only ID).
  - Access to the upper half of the bank (`addr` MSB = 1) with `prot[0]`=0.
  - An erroring transfer still completes with `ready`=1 and `slv_err`=1, registers are unchanged, and `rdata`=0.
- Write commit happens at the completion edge only. Byte lane i is updated iff `strb[i]`. A partial top lane covers only the remaining bits.
- Read: `rdata` carries the register value in every cycle where `ready`=1, and is 0 otherwise. Register 0 always reads `ID_VALUE`.
- `ready`, `rdata` and `slv_err` are decoded from registered state only; there is no combinational path from bus inputs.

## Timing
- Latency, counted from the setup-phase cycle: completion occurs in access cycle `WAIT_STATES`+1.
  - `WAIT_STATES`=0: setup cycle, then a single access cycle with `ready`=1.
  - `WAIT_STATES`=2: two access cycles with `ready`=0, then a third with `ready`=1.
- Back-to-back transfers: in the cycle after completion, `sel`=1 and `enable`=0 starts a new setup. There are no dead cycles beyond the protocol minimum.
- A write followed by a read of the same register returns the new value.
- Inputs are ignored in `ACCESS` except for the abort check. Changes to `addr`/`wdata` after setup have no effect.
- Reset asserted mid-transfer: immediate return to `IDLE`, `ready` drops asynchronously, and the pending write is discarded.
- When `sel[SEL_INDEX]`=0 the block must not react to other `sel` bits.

## Structure
- Package `apb_regbank_pkg`:
  - FSM state enum (`IDLE`, `ACCESS`).
  - `STRB_WIDTH` computation function.
  - Default `ID_VALUE` constant.
  - Register-0 index and privilege-bit index constants.
- Single sub-module `apb_wait_counter`: loadable down-counter with a zero flag.

## Test plan
- Reset, then read reg 0 with `WAIT_STATES`=1 -> `ready` high in the 2nd access cycle, `rdata`=32'hA5B0_0001, `slv_err`=0.
- Write 32'hDEAD_BEEF to reg 2 with `strb`=4'b1111, then write 32'h0000_1200 with `strb`=4'b0010, then read reg 2 -> 32'hDEAD_12EF.
- Write 32'h1 to reg 5 with `prot`=3'b000 -> `slv_err`=1; read reg 5 with `prot`=3'b001 -> 0, `slv_err`=0.
- Write to reg 0 -> `slv_err`=1; read reg 0 -> ID unchanged.
- Drop `enable` during the wait of a write of 32'h55 to reg 3 -> no `ready`; a later read of reg 3 returns 0.
- Assert `reset` during the access phase of a write to reg 1 -> `ready`=0 immediately; after release, reg 1 reads 0. Then run back-to-back writes to regs 1..7 with `WAIT_STATES`=0 -> one completion per two cycles and correct readback.
